axi4_slave_write_channel_ctrl: RTL

RTL slave-side write-channel controller that consumes AXI4 AW/W traffic and produces B responses plus a byte-enabled memory write port. It sits directly downstream of the master write path and upstream of the slave memory model. Its widths and encodings match the shared globals package: awburst_e, awsize_e and bresp_e encodings, and outstanding depth 16. Write addresses are queued for outstanding support. Data beats and responses are processed strictly in order, one burst at a time.

---
 rtl/axi4_slave_write_channel_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_write_channel_ctrl.sv
// AXI4 slave write-channel controller: queues AW requests, walks W beats of
// one burst at a time onto a byte-enabled memory write port, returns B in order.
module axi4_slave_write_channel_ctrl #(
  parameter int unsigned ADDRESS_WIDTH          = 32,
  parameter int unsigned DATA_WIDTH             = 64,
  parameter int unsigned ID_WIDTH               = 4,
  parameter int unsigned OUTSTANDING_FIFO_DEPTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = ADDRESS_WIDTH'(32'h0000_2FFF)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(OUTSTANDING_FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [2:0] SIZE_MAX    = 3'($clog2(STRB_W));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } aw_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

  // Burst parameters that can never be serviced correctly
  function automatic logic entry_err(input aw_entry_t e);
    logic [ADDRESS_WIDTH-1:0] align_mask;
    logic                     wrap_len_ok;
    align_mask  = (ADDRESS_WIDTH'(1) << e.size) - ADDRESS_WIDTH'(1);
    wrap_len_ok = (e.len == 8'd1) || (e.len == 8'd3) || (e.len == 8'd7) || (e.len == 8'd15);
    entry_err   = (e.burst == BURST_RSVD) ||
                  (e.size > SIZE_MAX) ||
                  ((e.burst == BURST_WRAP) && !wrap_len_ok) ||
                  ((e.burst == BURST_WRAP) && ((e.addr & align_mask) != '0));
  endfunction

  aw_entry_t              fifo_mem [OUTSTANDING_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_nxt;
  aw_entry_t              push_entry, head;
  logic                   push, pop;

  state_e                 state, state_nxt;
  logic [ID_WIDTH-1:0]    cur_id;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [7:0]             cur_len;
  logic [2:0]             cur_size;
  logic [1:0]             cur_burst;
  logic [7:0]             beat_cnt;
  logic                   err;

  logic                   beat, last_beat, addr_ok, proto_err, err_upd, wr_ok;
  logic [ADDRESS_WIDTH-1:0] size_bytes, container, wrap_mask, wrap_base, next_addr;
  logic [ADDRESS_WIDTH:0]   addr_plus1;

  assign push       = awvalid && awready;
  assign push_entry = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
  assign head       = fifo_mem[rd_ptr];
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  // AW queue storage
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // AW queue pointers, occupancy and registered awready
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      awready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      awready <= (count_nxt < CNT_W'(OUTSTANDING_FIFO_DEPTH));
    end
  end

  // Beat acceptance, address legality, protocol check and next beat address
  always_comb begin
    beat       = (state == S_DATA) && wvalid && wready;
    last_beat  = (beat_cnt == cur_len);
    addr_plus1 = {1'b0, cur_addr} + (ADDRESS_WIDTH + 1)'(1);
    addr_ok    = (addr_plus1 > {1'b0, MIN_ADDRESS}) && (cur_addr <= MAX_ADDRESS);
    proto_err  = (wlast != last_beat);
    wr_ok      = beat && !err && addr_ok;
    err_upd    = err || !addr_ok || proto_err;
    size_bytes = ADDRESS_WIDTH'(1) << cur_size;
    container  = ADDRESS_WIDTH'({1'b0, cur_len} + 9'd1) << cur_size;
    wrap_mask  = container - ADDRESS_WIDTH'(1);
    wrap_base  = cur_addr & ~wrap_mask;
    next_addr  = cur_addr;
    case (cur_burst)
      BURST_INCR: next_addr = (cur_addr & ~(size_bytes - ADDRESS_WIDTH'(1))) + size_bytes;
      BURST_WRAP: next_addr = wrap_base + ((cur_addr - wrap_base + size_bytes) & wrap_mask);
      default:    next_addr = cur_addr;
    endcase
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and queue pop
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (beat && last_beat) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst context, memory write port and channel handshake registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= wr_ok;
      if (wr_ok) begin
        mem_addr  <= cur_addr;
        mem_wdata <= wdata;
        mem_wstrb <= wstrb;
      end
      if (pop) begin
        cur_id    <= head.id;
        cur_addr  <= head.addr;
        cur_len   <= head.len;
        cur_size  <= head.size;
        cur_burst <= head.burst;
        beat_cnt  <= '0;
        err       <= entry_err(head);
      end else if (beat) begin
        cur_addr <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
        err      <= err_upd;
      end
      if (beat && last_beat) begin
        bid   <= cur_id;
        bresp <= err_upd ? RESP_SLVERR : RESP_OKAY;
      end
      wready <= (state_nxt == S_DATA);
      bvalid <= (state_nxt == S_RESP);
    end
  end

endmodule
